operand_fetch: RTL and testbench

Operand-fetch stage sitting directly upstream of the 32×32 register file. It accepts one instruction word per valid/ready handshake, stalls on RAW hazards using a 32-entry busy scoreboard, drives the register file's read addresses and read strobe, captures both operands one cycle later, and presents them with the decoded destination to the execute stage over a valid/ready handshake.

---
 rtl/operand_fetch_pkg.sv | 39 +++
 rtl/op_scoreboard.sv | 44 ++++
 rtl/operand_fetch.sv | 107 ++++++++++
 tb/tb_operand_fetch.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_fetch_pkg.sv
// ============================================================================
// operand_fetch_pkg : shared types and field positions for the operand-fetch stage
// Revision: 1.0
// ============================================================================
`default_nettype none

package operand_fetch_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  localparam int OPCODE_HI = 31;
  localparam int OPCODE_LO = 26;
  localparam int RS1_HI    = 25;
  localparam int RS1_LO    = 21;
  localparam int RS2_HI    = 20;
  localparam int RS2_LO    = 16;
  localparam int RD_HI     = 15;
  localparam int RD_LO     = 11;
  localparam int FUNCT_HI  = 10;
  localparam int FUNCT_LO  = 0;

  // Opcode bit that, when clear, marks an instruction as producing rd
  localparam int WRITES_RD_BIT = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } state_t;

  function automatic logic writes_rd(input logic [5:0] opcode);
    return ~opcode[WRITES_RD_BIT];
  endfunction

endpackage

`default_nettype wire

// File: rtl/op_scoreboard.sv
// ============================================================================
// op_scoreboard : per-register busy bits with set-over-clear update priority
// Revision: 1.0
// ============================================================================
`default_nettype none

module op_scoreboard #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic              rs1_busy,
  output logic              rs2_busy
);

  localparam int NREG = 1 << ADDR_W;

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_next;

  // Set is applied last so a new producer overrides a retiring one
  always_comb begin
    busy_next = busy;
    if (clr_en) busy_next[clr_addr] = 1'b0;
    if (set_en) busy_next[set_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy <= '0;
    else       busy <= busy_next;
  end

  assign rs1_busy = busy[rs1_addr];
  assign rs2_busy = busy[rs2_addr];

endmodule

`default_nettype wire

// File: rtl/operand_fetch.sv
// ============================================================================
// operand_fetch : hazard-checked operand fetch between decode and execute
// Revision: 1.0
// ============================================================================
`default_nettype none

module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  input  logic [DATA_W-1:0] instr,
  output logic              instr_ready,
  output logic [ADDR_W-1:0] rf_o1_addr,
  output logic [ADDR_W-1:0] rf_o2_addr,
  output logic              rf_read,
  input  logic [DATA_W-1:0] rf_o1,
  input  logic [DATA_W-1:0] rf_o2,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [ADDR_W-1:0] op_rd,
  output logic [5:0]        op_opcode,
  output logic [10:0]       op_funct
);

  state_t            state;
  state_t            state_next;
  logic [DATA_W-1:0] instr_q;
  logic              rs1_busy;
  logic              rs2_busy;
  logic              hazard;
  logic              accept;
  logic              handshake;

  assign hazard    = rs1_busy | rs2_busy;
  assign accept    = instr_valid & instr_ready;
  assign handshake = op_valid & op_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (instr_valid) state_next = ISSUE;
      ISSUE:   if (!hazard)     state_next = WAIT;
      WAIT:                     state_next = OUT;
      OUT:     if (op_ready)    state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  always_comb begin
    instr_ready = (state == IDLE);
    rf_read     = (state == ISSUE) & ~hazard;
    op_valid    = (state == OUT);
  end

  // The latch only loads in IDLE, so decoded fields stay stable through OUT
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q <= '0;
      op_a    <= '0;
      op_b    <= '0;
    end else begin
      if (accept) instr_q <= instr;
      if (state == WAIT) begin
        op_a <= rf_o1;
        op_b <= rf_o2;
      end
    end
  end

  assign rf_o1_addr = instr_q[RS1_HI:RS1_LO];
  assign rf_o2_addr = instr_q[RS2_HI:RS2_LO];
  assign op_rd      = instr_q[RD_HI:RD_LO];
  assign op_opcode  = instr_q[OPCODE_HI:OPCODE_LO];
  assign op_funct   = instr_q[FUNCT_HI:FUNCT_LO];

  op_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .set_en   (handshake & writes_rd(op_opcode)),
    .set_addr (op_rd),
    .clr_en   (wb_valid),
    .clr_addr (wb_addr),
    .rs1_addr (rf_o1_addr),
    .rs2_addr (rf_o2_addr),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy)
  );

endmodule

`default_nettype wire

// File: tb/tb_operand_fetch.sv
// ============================================================================
// tb_operand_fetch : directed stimulus with a transaction-level reference model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [4:0]  rf_o1_addr, rf_o2_addr;
  logic        rf_read;
  logic [31:0] rf_o1, rf_o2;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        op_valid;
  logic        op_ready;
  logic [31:0] op_a, op_b;
  logic [4:0]  op_rd;
  logic [5:0]  op_opcode;
  logic [10:0] op_funct;

  int total = 0;
  int bad   = 0;

  logic [31:0] rf [32];

  operand_fetch dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .rf_o1_addr(rf_o1_addr), .rf_o2_addr(rf_o2_addr), .rf_read(rf_read),
    .rf_o1(rf_o1), .rf_o2(rf_o2),
    .wb_valid(wb_valid), .wb_addr(wb_addr),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .op_rd(op_rd),
    .op_opcode(op_opcode), .op_funct(op_funct)
  );

  always #5 clk = ~clk;

  // Register file: reads are sampled before the same-edge write lands
  always @(posedge clk) begin
    if (rf_read) begin
      rf_o1 <= rf[rf_o1_addr];
      rf_o2 <= rf[rf_o2_addr];
    end
    if (wb_valid) rf[wb_addr] <= wb_data;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s got=timeout want=event @%0t", name, $time);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [5:0] opc, input logic [4:0] s1,
                                     input logic [4:0] s2, input logic [4:0] d,
                                     input logic [10:0] fn);
    return {opc, s1, s2, d, fn};
  endfunction

  task automatic send(input logic [31:0] w);
    int n = 0;
    instr       = w;
    instr_valid = 1'b1;
    while (!instr_ready && n < 100) begin
      tick;
      n++;
    end
    if (!instr_ready) timeout_fail("send_accept");
    tick;
    instr_valid = 1'b0;
  endtask

  // Reference model: one instruction in flight, operands read from the
  // register file on the first hazard-free cycle, presented two edges later.
  logic [31:0] m_ir;
  logic [31:0] m_busy;
  logic [31:0] m_a, m_b;
  bit          m_inflight, m_issued;
  int          m_since_read;
  bit          e_ready, e_read, e_valid, hs;

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_instr_ready", 32'(instr_ready), 1);
      chk("rst_op_valid", 32'(op_valid), 0);
      chk("rst_rf_read", 32'(rf_read), 0);
      m_inflight   = 0;
      m_issued     = 0;
      m_since_read = 0;
      m_busy       = '0;
      m_ir         = '0;
    end else begin
      e_ready = !m_inflight;
      e_read  = m_inflight && !m_issued && !(m_busy[m_ir[25:21]] || m_busy[m_ir[20:16]]);
      e_valid = m_inflight && m_issued && (m_since_read >= 1);

      chk("m_instr_ready", 32'(instr_ready), 32'(e_ready));
      chk("m_rf_read", 32'(rf_read), 32'(e_read));
      chk("m_op_valid", 32'(op_valid), 32'(e_valid));
      if (m_inflight) begin
        chk("m_rf_o1_addr", 32'(rf_o1_addr), 32'(m_ir[25:21]));
        chk("m_rf_o2_addr", 32'(rf_o2_addr), 32'(m_ir[20:16]));
      end
      if (e_valid) begin
        chk("m_op_a", op_a, m_a);
        chk("m_op_b", op_b, m_b);
        chk("m_op_rd", 32'(op_rd), 32'(m_ir[15:11]));
        chk("m_op_opcode", 32'(op_opcode), 32'(m_ir[31:26]));
        chk("m_op_funct", 32'(op_funct), 32'(m_ir[10:0]));
      end

      // Advance the model across the coming rising edge
      hs = e_valid && op_ready;
      if (e_read) begin
        m_issued     = 1;
        m_since_read = 0;
        m_a          = rf[m_ir[25:21]];
        m_b          = rf[m_ir[20:16]];
      end else if (m_issued) begin
        m_since_read++;
      end
      if (wb_valid) m_busy[wb_addr] = 1'b0;
      if (hs) begin
        if (!m_ir[31]) m_busy[m_ir[15:11]] = 1'b1;
        m_inflight = 0;
      end
      if (e_ready && instr_valid) begin
        m_inflight = 1;
        m_issued   = 0;
        m_ir       = instr;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    rf[30]      = 32'd111111;
    rf[10]      = 32'd9999999;
    rf_o1       = '0;
    rf_o2       = '0;
    reset       = 1'b1;
    instr_valid = 1'b0;
    instr       = '0;
    wb_valid    = 1'b0;
    wb_addr     = '0;
    wb_data     = '0;
    op_ready    = 1'b1;

    tick;
    chk("reset_op_a", op_a, 0);
    chk("reset_op_b", op_b, 0);
    chk("reset_op_rd", 32'(op_rd), 0);
    chk("reset_op_opcode", 32'(op_opcode), 0);
    chk("reset_op_funct", 32'(op_funct), 0);
    chk("reset_rf_o1_addr", 32'(rf_o1_addr), 0);
    chk("reset_rf_o2_addr", 32'(rf_o2_addr), 0);
    tick;
    reset = 1'b0;
    tick;

    // Basic fetch
    send(mk(6'h00, 5'd30, 5'd10, 5'd5, 11'h000));
    chk("t1_read_pulse", 32'(rf_read), 1);
    tick;
    chk("t1_wait_no_valid", 32'(op_valid), 0);
    chk("t1_wait_no_read", 32'(rf_read), 0);
    tick;
    chk("t1_valid", 32'(op_valid), 1);
    chk("t1_op_a", op_a, 32'd111111);
    chk("t1_op_b", op_b, 32'd9999999);
    chk("t1_op_rd", 32'(op_rd), 5);
    tick;

    // RAW stall on r5, released by writeback of 42
    send(mk(6'h20, 5'd5, 5'd0, 5'd6, 11'h000));
    repeat (3) begin
      chk("t2_stall", 32'(rf_read), 0);
      tick;
    end
    wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'd42;
    chk("t2_stall_wb_cycle", 32'(rf_read), 0);
    tick;
    wb_valid = 1'b0;
    chk("t2_release", 32'(rf_read), 1);
    tick;
    tick;
    chk("t2_valid", 32'(op_valid), 1);
    chk("t2_op_a", op_a, 32'd42);
    tick;

    // Backpressure
    op_ready = 1'b0;
    send(mk(6'h01, 5'd30, 5'd10, 5'd12, 11'h3AB));
    tick;
    tick;
    repeat (5) begin
      chk("t3_hold_valid", 32'(op_valid), 1);
      chk("t3_hold_ready", 32'(instr_ready), 0);
      chk("t3_hold_op_a", op_a, 32'd111111);
      chk("t3_hold_rd", 32'(op_rd), 12);
      chk("t3_hold_funct", 32'(op_funct), 32'h3AB);
      tick;
    end
    op_ready = 1'b1;
    tick;

    // Set/clear collision on r7: set must win
    op_ready = 1'b0;
    send(mk(6'h00, 5'd30, 5'd10, 5'd7, 11'h000));
    tick;
    tick;
    op_ready = 1'b1; wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'd77;
    tick;
    wb_valid = 1'b0;
    send(mk(6'h20, 5'd7, 5'd12, 5'd8, 11'h000));
    chk("t4_stall_r7", 32'(rf_read), 0);
    tick;
    wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'd70;
    tick;
    wb_valid = 1'b0;
    chk("t4_stall_r12", 32'(rf_read), 0);
    wb_valid = 1'b1; wb_addr = 5'd12; wb_data = 32'd1212;
    tick;
    wb_valid = 1'b0;
    chk("t4_release", 32'(rf_read), 1);
    tick;
    tick;
    chk("t4_op_a", op_a, 32'd70);
    chk("t4_op_b", op_b, 32'd1212);
    tick;

    // Opcode with bit 5 set never marks rd busy
    send(mk(6'h20, 5'd30, 5'd10, 5'd9, 11'h000));
    tick;
    tick;
    tick;
    send(mk(6'h00, 5'd9, 5'd30, 5'd20, 11'h000));
    chk("t5_no_stall_r9", 32'(rf_read), 1);
    tick;
    tick;
    chk("t5_op_b", op_b, 32'd111111);
    tick;

    // Asynchronous reset in WAIT clears everything, including busy[20]
    send(mk(6'h00, 5'd1, 5'd2, 5'd3, 11'h000));
    tick;
    reset = 1'b1;
    #1;
    chk("t6_async_valid", 32'(op_valid), 0);
    chk("t6_async_ready", 32'(instr_ready), 1);
    tick;
    reset = 1'b0;
    send(mk(6'h00, 5'd20, 5'd30, 5'd4, 11'h055));
    chk("t6_no_stall_r20", 32'(rf_read), 1);
    tick;
    tick;
    chk("t6_valid", 32'(op_valid), 1);
    chk("t6_op_b", op_b, 32'd111111);
    chk("t6_op_rd", 32'(op_rd), 4);
    tick;
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
